// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer controllers.
package fifo_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int PTR_W      = DEF_ADDR_W + 1;

    // Conversion helpers work on a wide container; callers size-cast to their pointer width.
    // Zero-extension is transparent to both conversions.
    localparam int MAX_PTR_W = 16;
    typedef logic [MAX_PTR_W-1:0] ptr_wide_t;

    function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
        ptr_wide_t b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchroniser for a pointer crossing clock domains.
module fifo_ptr_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q1;

    // Two-stage capture of the foreign-domain pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/flag controller of the async FIFO.
module fifo_rd_ctrl import fifo_pkg::*; #(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AE_THRESH = 1,
    parameter bit GRAY_PTR  = 1'b1
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              rinc,
    input  logic [ADDR_W:0]   wptr_async,
    output logic [ADDR_W:0]   rptr,
    output logic [ADDR_W-1:0] raddr,
    output logic              rclken,
    output logic              rempty,
    output logic              ralmost_empty,
    output logic [ADDR_W:0]   rlevel,
    output logic              runderflow
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

    logic [PW-1:0] wq2;
    logic [PW-1:0] wq2_bin;
    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] rptr_next;
    logic [PW-1:0] rptr_enc_next;

    fifo_ptr_sync #(.W(PW)) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (wptr_async),
        .q     (wq2)
    );

    // Decode the synchronised write pointer and derive flags and memory controls.
    always_comb begin
        wq2_bin       = GRAY_PTR ? PW'(gray2bin(ptr_wide_t'(wq2))) : wq2;
        rempty        = (rptr_bin == wq2_bin);
        rlevel        = wq2_bin - rptr_bin;
        ralmost_empty = (rlevel <= AE_LIM);
        rclken        = rinc & ~rempty;
        raddr         = rptr_bin[ADDR_W-1:0];
        rptr_next     = rptr_bin + PW'(1);
        rptr_enc_next = GRAY_PTR ? PW'(bin2gray(ptr_wide_t'(rptr_next))) : rptr_next;
    end

    // Pointer registers; the outgoing encoding is held in its own flop so the crossing path is glitch-free.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rptr_bin <= '0;
            rptr     <= '0;
        end else if (rclken) begin
            rptr_bin <= rptr_next;
            rptr     <= rptr_enc_next;
        end
    end

    // Sticky underflow: a read request against an empty FIFO, cleared only by reset.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            runderflow <= 1'b0;
        end else if (rinc && rempty) begin
            runderflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for the read-side FIFO controller.
module tb_fifo_rd_ctrl;

    logic       rclk;
    logic       rrst_n;
    logic       rinc;
    logic [3:0] wptr_g;
    logic [3:0] wptr_b;

    logic [3:0] m_rptr, a_rptr, b_rptr;
    logic [2:0] m_raddr, a_raddr, b_raddr;
    logic       m_rclken, a_rclken, b_rclken;
    logic       m_rempty, a_rempty, b_rempty;
    logic       m_ae, a_ae, b_ae;
    logic [3:0] m_rlevel, a_rlevel, b_rlevel;
    logic       m_unf, a_unf, b_unf;

    int checks   = 0;
    int failures = 0;
    logic [2:0] exp_q[$];

    fifo_rd_ctrl #(.ADDR_W(3), .AE_THRESH(1), .GRAY_PTR(1'b1)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .wptr_async(wptr_g),
        .rptr(m_rptr), .raddr(m_raddr), .rclken(m_rclken), .rempty(m_rempty),
        .ralmost_empty(m_ae), .rlevel(m_rlevel), .runderflow(m_unf)
    );

    fifo_rd_ctrl #(.ADDR_W(3), .AE_THRESH(2), .GRAY_PTR(1'b1)) dut_ae2 (
        .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .wptr_async(wptr_g),
        .rptr(a_rptr), .raddr(a_raddr), .rclken(a_rclken), .rempty(a_rempty),
        .ralmost_empty(a_ae), .rlevel(a_rlevel), .runderflow(a_unf)
    );

    fifo_rd_ctrl #(.ADDR_W(3), .AE_THRESH(2), .GRAY_PTR(1'b0)) dut_bin (
        .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .wptr_async(wptr_b),
        .rptr(b_rptr), .raddr(b_raddr), .rclken(b_rclken), .rempty(b_rempty),
        .ralmost_empty(b_ae), .rlevel(b_rlevel), .runderflow(b_unf)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        rinc   = 1'b0;
        wptr_g = 4'b0000;
        wptr_b = 4'b0000;
        tick();
        tick();
        rrst_n = 1'b1;
    endtask

    // Monitor: every memory read the main DUT issues is matched against the expected address queue.
    always @(negedge rclk) begin
        if (rrst_n && m_rclken) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read actual_raddr=%0d expected=none", m_raddr);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (m_raddr !== e) begin
                    failures++;
                    $display("FAIL read_raddr actual=%0d expected=%0d", m_raddr, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset values and sticky underflow
        rrst_n = 1'b0;
        rinc   = 1'b0;
        wptr_g = 4'b0000;
        wptr_b = 4'b0000;
        #2;
        chk("rst_rempty", m_rempty, 1);
        chk("rst_rlevel", m_rlevel, 0);
        chk("rst_rptr", m_rptr, 0);
        chk("rst_unf", m_unf, 0);
        chk("rst_ae", m_ae, 1);
        chk("rst_rclken", m_rclken, 0);
        tick();
        tick();
        rrst_n = 1'b1;
        tick();
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("unf_set", m_unf, 1);
        chk("unf_rptr", m_rptr, 0);
        tick();
        chk("unf_sticky", m_unf, 1);

        // 2: single write seen after two edges, then one read
        wptr_g = 4'b0001;
        tick();
        chk("sync_edge1_rempty", m_rempty, 1);
        tick();
        chk("sync_edge2_rempty", m_rempty, 0);
        chk("sync_edge2_rlevel", m_rlevel, 1);
        exp_q.push_back(3'd0);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("rd1_rptr", m_rptr, 4'b0001);
        chk("rd1_rempty", m_rempty, 1);
        chk("rd1_rlevel", m_rlevel, 0);

        // 3: full FIFO, drained by eight reads
        do_reset();
        wptr_g = 4'b1100;
        tick();
        tick();
        chk("full_rlevel", m_rlevel, 8);
        chk("full_ae", m_ae, 0);
        chk("full_rempty", m_rempty, 0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(i[2:0]);
            rinc = 1'b1;
            tick();
            chk("drain_rlevel", m_rlevel, 7 - i);
            chk("drain_ae", m_ae, ((7 - i) <= 1) ? 1 : 0);
        end
        rinc = 1'b0;
        chk("drain_rempty", m_rempty, 1);
        chk("drain_rptr", m_rptr, 4'b1100);

        // 4: pointer wrap through 15 -> 0
        wptr_g = 4'b1010;
        tick();
        tick();
        chk("wrap_lvl4", m_rlevel, 4);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(i[2:0]);
            rinc = 1'b1;
            tick();
        end
        rinc = 1'b0;
        chk("wrap_lvl1", m_rlevel, 1);
        wptr_g = 4'b1000;
        tick();
        chk("wrap_mid1_rempty", m_rempty, 0);
        tick();
        chk("wrap_w15_rlevel", m_rlevel, 4);
        wptr_g = 4'b0000;
        tick();
        chk("wrap_mid2_rempty", m_rempty, 0);
        chk("wrap_mid2_rlevel", m_rlevel, 4);
        tick();
        chk("wrap_w0_rlevel", m_rlevel, 5);
        chk("wrap_w0_rempty", m_rempty, 0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(3'(i + 3));
            rinc = 1'b1;
            tick();
            chk("wrap_drain_rlevel", m_rlevel, 4 - i);
        end
        rinc = 1'b0;
        chk("wrap_rempty", m_rempty, 1);
        chk("wrap_rptr", m_rptr, 4'b0000);

        // 5: AE_THRESH=2, Gray and binary variants must agree
        do_reset();
        wptr_g = 4'b0010;
        wptr_b = 4'b0011;
        tick();
        tick();
        chk("ae_g_lvl3", a_rlevel, 3);
        chk("ae_b_lvl3", b_rlevel, 3);
        chk("ae_g_ae3", a_ae, 0);
        chk("ae_b_ae3", b_ae, 0);
        exp_q.push_back(3'd0);
        rinc = 1'b1;
        tick();
        chk("ae_g_lvl2", a_rlevel, 2);
        chk("ae_b_lvl2", b_rlevel, 2);
        chk("ae_g_ae2", a_ae, 1);
        chk("ae_b_ae2", b_ae, 1);
        chk("ae_m_ae2", m_ae, 0);
        exp_q.push_back(3'd1);
        tick();
        chk("ae_g_ae1", a_ae, 1);
        chk("ae_b_ae1", b_ae, 1);
        chk("ae_m_ae1", m_ae, 1);
        chk("ae_g_rptr", a_rptr, 4'b0011);
        chk("ae_b_rptr", b_rptr, 4'b0010);
        exp_q.push_back(3'd2);
        tick();
        rinc = 1'b0;
        chk("ae_g_rempty", a_rempty, 1);
        chk("ae_b_rempty", b_rempty, 1);
        chk("ae_b_unf", b_unf, 0);

        // 6: asynchronous reset mid-burst at level 5
        do_reset();
        wptr_g = 4'b0101;
        wptr_b = 4'b0110;
        tick();
        tick();
        chk("burst_lvl6", m_rlevel, 6);
        exp_q.push_back(3'd0);
        rinc = 1'b1;
        tick();
        chk("burst_lvl5", m_rlevel, 5);
        chk("burst_b_lvl5", b_rlevel, 5);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("arst_rempty", m_rempty, 1);
        chk("arst_rlevel", m_rlevel, 0);
        chk("arst_rptr", m_rptr, 0);
        chk("arst_raddr", m_raddr, 0);
        chk("arst_rclken", m_rclken, 0);
        chk("arst_ae", m_ae, 1);
        chk("arst_b_rlevel", b_rlevel, 0);
        chk("arst_b_rptr", b_rptr, 0);
        rinc = 1'b0;
        tick();
        chk("arst_hold_rlevel", m_rlevel, 0);
        chk("arst_hold_unf", m_unf, 0);
        rrst_n = 1'b1;
        tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
